// File: rtl/ysyx_24080006_idq.sv
// Decoded-instruction queue between IFU and EXU. Register usage is pre-decoded at enqueue,
// and a per-register pending-write counter gates issue of the head entry.
module ysyx_24080006_idq #(
   parameter int DEPTH     = 4,
   parameter int REG_WIDTH = 4,
   parameter int CNT_W     = 2
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          in_inst,
   input  logic [31:0]          in_pc,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          out_inst,
   output logic [31:0]          out_pc,
   output logic [REG_WIDTH-1:0] out_rs1,
   output logic [REG_WIDTH-1:0] out_rs2,
   output logic [REG_WIDTH-1:0] out_rd,
   output logic                 out_reg_we,
   output logic                 out_inst_err,
   input  logic                 wb_valid,
   input  logic [REG_WIDTH-1:0] wb_rd
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int NREG  = 1 << REG_WIDTH;

   typedef enum logic [6:0] {
      OPC_LUI      = 7'b0110111,
      OPC_AUIPC    = 7'b0010111,
      OPC_JAL      = 7'b1101111,
      OPC_JALR     = 7'b1100111,
      OPC_BRANCH   = 7'b1100011,
      OPC_LOAD     = 7'b0000011,
      OPC_STORE    = 7'b0100011,
      OPC_OP_IMM   = 7'b0010011,
      OPC_OP       = 7'b0110011,
      OPC_MISC_MEM = 7'b0001111,
      OPC_SYSTEM   = 7'b1110011
   } opcode_e;

   typedef struct packed {
      logic [31:0]          inst;
      logic [31:0]          pc;
      logic [REG_WIDTH-1:0] rs1;
      logic [REG_WIDTH-1:0] rs2;
      logic [REG_WIDTH-1:0] rd;
      logic                 we;
      logic                 err;
   } entry_t;

   entry_t             q [DEPTH];
   logic [PTR_W-1:0]   rd_ptr, wr_ptr;
   logic [PTR_W:0]     count;
   logic [CNT_W-1:0]   cnt [NREG];

   entry_t             head, dec;
   logic               full, empty, hazard, enq, fire;
   logic [NREG-1:0]    inc_v, dec_v;

   function automatic logic out_of_range(input logic [4:0] f);
      if (REG_WIDTH >= 5) return 1'b0;
      return (f >> REG_WIDTH) != 5'd0;
   endfunction

   always_comb begin
      logic       u1, u2, ud, err;
      logic [4:0] f_rs1, f_rs2, f_rd;
      f_rs1 = in_inst[19:15];
      f_rs2 = in_inst[24:20];
      f_rd  = in_inst[11:7];
      u1 = 1'b0; u2 = 1'b0; ud = 1'b0; err = 1'b0;
      case (opcode_e'(in_inst[6:0]))
         OPC_LUI, OPC_AUIPC, OPC_JAL:      ud = 1'b1;
         OPC_OP:                           begin u1 = 1'b1; u2 = 1'b1; ud = 1'b1; end
         OPC_OP_IMM, OPC_LOAD, OPC_JALR:   begin u1 = 1'b1; ud = 1'b1; end
         OPC_STORE, OPC_BRANCH:            begin u1 = 1'b1; u2 = 1'b1; end
         OPC_SYSTEM: begin
            if (in_inst[14:12] != 3'b000) begin
               ud = 1'b1;
               u1 = ~in_inst[14];
            end
         end
         OPC_MISC_MEM:                     ;
         default:                          err = 1'b1;
      endcase
      if ((u1 && out_of_range(f_rs1)) || (u2 && out_of_range(f_rs2)) || (ud && out_of_range(f_rd)))
         err = 1'b1;
      if (err) begin u1 = 1'b0; u2 = 1'b0; ud = 1'b0; end
      dec      = '0;
      dec.inst = in_inst;
      dec.pc   = in_pc;
      dec.rs1  = u1 ? f_rs1[REG_WIDTH-1:0] : '0;
      dec.rs2  = u2 ? f_rs2[REG_WIDTH-1:0] : '0;
      dec.rd   = ud ? f_rd[REG_WIDTH-1:0]  : '0;
      dec.we   = ud && (f_rd[REG_WIDTH-1:0] != '0);
      dec.err  = err;
   end

   assign head  = q[rd_ptr];
   assign full  = count == (PTR_W+1)'(DEPTH);
   assign empty = count == '0;

   // Unused sources are stored as x0 and cnt[0] can never leave zero, so the use flags fold away.
   assign hazard = (cnt[head.rs1] != '0) || (cnt[head.rs2] != '0) ||
                   (head.we && (cnt[head.rd] == '1));

   assign in_ready  = !full;
   assign out_valid = !empty && !hazard && !flush;
   assign enq       = in_valid && in_ready && !flush;
   assign fire      = out_valid && out_ready;

   assign out_inst     = head.inst;
   assign out_pc       = head.pc;
   assign out_rs1      = head.rs1;
   assign out_rs2      = head.rs2;
   assign out_rd       = head.rd;
   assign out_reg_we   = head.we;
   assign out_inst_err = head.err;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) q[i] <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (enq) begin
            q[wr_ptr] <= dec;
            wr_ptr    <= wr_ptr + PTR_W'(1);
         end
         if (fire) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({enq, fire})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: ;
         endcase
      end
   end

   always_comb begin
      inc_v = '0;
      dec_v = '0;
      for (int unsigned r = 0; r < NREG; r++) begin
         inc_v[r] = fire && head.we && (head.rd == REG_WIDTH'(r));
         dec_v[r] = wb_valid && (wb_rd == REG_WIDTH'(r)) && (r != 0) && (cnt[r] != '0);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int unsigned r = 0; r < NREG; r++) cnt[r] <= '0;
      end else begin
         for (int unsigned r = 0; r < NREG; r++) begin
            if (inc_v[r] && !dec_v[r])      cnt[r] <= cnt[r] + CNT_W'(1);
            else if (dec_v[r] && !inc_v[r]) cnt[r] <= cnt[r] - CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_ysyx_24080006_idq.sv
// Directed bench for the decoded-instruction queue: decode table plus hazard, full and flush sequences.
module tb_ysyx_24080006_idq;

   logic        clock = 1'b0;
   logic        reset;
   logic        flush, in_valid, in_ready, out_valid, out_ready, out_reg_we, out_inst_err, wb_valid;
   logic [31:0] in_inst, in_pc, out_inst, out_pc;
   logic [3:0]  out_rs1, out_rs2, out_rd, wb_rd;

   int checks = 0;
   int errors = 0;

   ysyx_24080006_idq #(.DEPTH(4), .REG_WIDTH(4), .CNT_W(2)) dut (
      .clock(clock), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
      .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
      .out_reg_we(out_reg_we), .out_inst_err(out_inst_err),
      .wb_valid(wb_valid), .wb_rd(wb_rd)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] inst;
      logic [3:0]  rs1, rs2, rd;
      logic        we, err;
   } vec_t;

   vec_t vecs [14];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic enq(input logic [31:0] inst, input logic [31:0] pc);
      in_valid = 1'b1; in_inst = inst; in_pc = pc;
      @(negedge clock);
      in_valid = 1'b0;
   endtask

   task automatic fire();
      out_ready = 1'b1;
      @(negedge clock);
      out_ready = 1'b0;
   endtask

   task automatic wb(input logic [3:0] r);
      wb_valid = 1'b1; wb_rd = r;
      @(negedge clock);
      wb_valid = 1'b0;
   endtask

   initial begin
      vecs[0]  = '{32'h003100B3, 4'd2, 4'd3, 4'd1,  1'b1, 1'b0}; // add x1,x2,x3
      vecs[1]  = '{32'h00100293, 4'd0, 4'd0, 4'd5,  1'b1, 1'b0}; // addi x5,x0,1
      vecs[2]  = '{32'h0020A223, 4'd1, 4'd2, 4'd0,  1'b0, 1'b0}; // sw x2,4(x1)
      vecs[3]  = '{32'h12345537, 4'd0, 4'd0, 4'd10, 1'b1, 1'b0}; // lui x10
      vecs[4]  = '{32'h00000073, 4'd0, 4'd0, 4'd0,  1'b0, 1'b0}; // ecall
      vecs[5]  = '{32'h300211F3, 4'd4, 4'd0, 4'd3,  1'b1, 1'b0}; // csrrw x3,mstatus,x4
      vecs[6]  = '{32'h3002D173, 4'd0, 4'd0, 4'd2,  1'b1, 1'b0}; // csrrwi x2,mstatus,5
      vecs[7]  = '{32'h0FF0000F, 4'd0, 4'd0, 4'd0,  1'b0, 1'b0}; // fence
      vecs[8]  = '{32'h00208833, 4'd0, 4'd0, 4'd0,  1'b0, 1'b1}; // add x16,x1,x2
      vecs[9]  = '{32'h003100FF, 4'd0, 4'd0, 4'd0,  1'b0, 1'b1}; // opcode 0x7F
      vecs[10] = '{32'h000000EF, 4'd0, 4'd0, 4'd1,  1'b1, 1'b0}; // jal x1,0
      vecs[11] = '{32'h00208063, 4'd1, 4'd2, 4'd0,  1'b0, 1'b0}; // beq x1,x2,0
      vecs[12] = '{32'h0008A283, 4'd0, 4'd0, 4'd0,  1'b0, 1'b1}; // lw x5,0(x17)
      vecs[13] = '{32'h00208033, 4'd1, 4'd2, 4'd0,  1'b0, 1'b0}; // add x0,x1,x2

      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0;
      out_ready = 1'b0; wb_valid = 1'b0; wb_rd = '0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      #1;
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_out_inst", out_inst, 32'd0);
      chk("reset_out_pc", out_pc, 32'd0);
      @(negedge clock);

      for (int i = 0; i < 14; i++) begin
         enq(vecs[i].inst, 32'h1000 + 32'(i) * 4);
         chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
         chk($sformatf("v%0d_inst", i), out_inst, vecs[i].inst);
         chk($sformatf("v%0d_pc", i), out_pc, 32'h1000 + 32'(i) * 4);
         chk($sformatf("v%0d_rs1", i), 32'(out_rs1), 32'(vecs[i].rs1));
         chk($sformatf("v%0d_rs2", i), 32'(out_rs2), 32'(vecs[i].rs2));
         chk($sformatf("v%0d_rd", i), 32'(out_rd), 32'(vecs[i].rd));
         chk($sformatf("v%0d_we", i), 32'(out_reg_we), 32'(vecs[i].we));
         chk($sformatf("v%0d_err", i), 32'(out_inst_err), 32'(vecs[i].err));
         fire();
         chk($sformatf("v%0d_empty", i), 32'(out_valid), 32'd0);
         if (vecs[i].we) wb(vecs[i].rd);
      end

      // RAW stall on x5, released one cycle after the writeback
      enq(32'h00100293, 32'h2000);
      fire();
      enq(32'h00528333, 32'h2004);
      chk("raw_stall0", 32'(out_valid), 32'd0);
      @(negedge clock);
      chk("raw_stall1", 32'(out_valid), 32'd0);
      wb_valid = 1'b1; wb_rd = 4'd5;
      #1;
      chk("raw_no_bypass", 32'(out_valid), 32'd0);
      @(negedge clock);
      wb_valid = 1'b0;
      chk("raw_release", 32'(out_valid), 32'd1);
      fire();
      wb(4'd6);

      // WAW saturation on x7
      for (int k = 0; k < 3; k++) begin
         enq(32'h00100393, 32'h3000 + 32'(k) * 4);
         chk($sformatf("waw_issue%0d", k), 32'(out_valid), 32'd1);
         fire();
      end
      enq(32'h00100393, 32'h300C);
      chk("waw_saturated", 32'(out_valid), 32'd0);
      wb(4'd7);
      chk("waw_release", 32'(out_valid), 32'd1);
      fire();
      repeat (3) wb(4'd7);
      enq(32'h000380B3, 32'h3010);
      chk("waw_drained", 32'(out_valid), 32'd1);
      fire();
      wb(4'd1);

      // full queue, blocked enqueue on pop cycle, then flush
      enq(32'h00100493, 32'h4000);
      fire();
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("fill_ready%0d", k), 32'(in_ready), 32'd1);
         enq(32'h00000013, 32'h4100 + 32'(k) * 4);
      end
      chk("full_ready", 32'(in_ready), 32'd0);
      chk("full_head_pc", out_pc, 32'h4100);
      in_valid = 1'b1; in_inst = 32'h00000013; in_pc = 32'h4200; out_ready = 1'b1;
      @(negedge clock);
      in_valid = 1'b0; out_ready = 1'b0;
      chk("pop_reopens_ready", 32'(in_ready), 32'd1);
      chk("pop_head_pc", out_pc, 32'h4104);
      flush = 1'b1; in_valid = 1'b1; in_pc = 32'h4300;
      #1;
      chk("flush_masks_valid", 32'(out_valid), 32'd0);
      @(negedge clock);
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_valid", 32'(out_valid), 32'd0);
      chk("flush_ready", 32'(in_ready), 32'd1);
      enq(32'h000480B3, 32'h4400);
      chk("flush_keeps_cnt", 32'(out_valid), 32'd0);
      chk("flush_ptr_head_pc", out_pc, 32'h4400);
      wb(4'd9);
      chk("flush_cnt_release", 32'(out_valid), 32'd1);
      fire();
      wb(4'd1);

      // simultaneous enqueue and pop while not full
      enq(32'h00000013, 32'h5000);
      in_valid = 1'b1; in_inst = 32'h00000013; in_pc = 32'h5004; out_ready = 1'b1;
      @(negedge clock);
      in_valid = 1'b0; out_ready = 1'b0;
      chk("enq_pop_valid", 32'(out_valid), 32'd1);
      chk("enq_pop_pc", out_pc, 32'h5004);
      fire();
      chk("enq_pop_empty", 32'(out_valid), 32'd0);

      // same-cycle fire and writeback on x4 leaves cnt[4]=1
      enq(32'h00100213, 32'h6000);
      fire();
      enq(32'h00100213, 32'h6004);
      chk("x4_second_ok", 32'(out_valid), 32'd1);
      out_ready = 1'b1; wb_valid = 1'b1; wb_rd = 4'd4;
      @(negedge clock);
      out_ready = 1'b0; wb_valid = 1'b0;
      enq(32'h000200B3, 32'h6008);
      chk("x4_net_one", 32'(out_valid), 32'd0);
      wb(4'd4);
      chk("x4_cleared", 32'(out_valid), 32'd1);
      fire();
      wb(4'd1);
      wb(4'd4);
      wb(4'd0);
      enq(32'h000200B3, 32'h6010);
      chk("x4_no_underflow", 32'(out_valid), 32'd1);
      fire();
      wb(4'd1);
      enq(32'h00100293, 32'h6014);
      chk("x0_wb_ignored", 32'(out_valid), 32'd1);
      fire();
      wb(4'd5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
